ibex_rf_wb_arbiter: RTL and testbench
=====================================

Name: ibex_rf_wb_arbiter

Overview:
Write-side companion of the flip-flop register file. It merges register writebacks from the EX stage (ALU/MULT results, valid/ready handshake) and the LSU (load data, always accepted) onto the register file's single write port. EX results that lose arbitration are buffered in a small in-order FIFO. The block reports pending-write hazards for the two read addresses so the ID stage can stall.

Parameters:
RV32E, 0, when 1 only x0..x15 exist; a write to waddr[4]=1 is illegal.
DataWidth, 32, width of write data.
FifoDepth, 2, number of buffered EX writebacks (2..4).

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
ex_valid_i  input  1  EX writeback valid
ex_ready_o  output  1  EX writeback accepted this cycle when valid & ready
ex_waddr_i  input  5  EX destination register
ex_wdata_i  input  DataWidth  EX result
lsu_valid_i  input  1  LSU writeback valid (no backpressure)
lsu_waddr_i  input  5  LSU destination register
lsu_wdata_i  input  DataWidth  load data
flush_i  input  1  discard all buffered EX writebacks
raddr_a_i  input  5  ID read address A
raddr_b_i  input  5  ID read address B
hazard_a_o  output  1  raddr_a_i has a write pending in this block
hazard_b_o  output  1  raddr_b_i has a write pending in this block
rf_waddr_o  output  5  register file write address
rf_wdata_o  output  DataWidth  register file write data
rf_we_o  output  1  register file write enable
fifo_count_o  output  3  current FIFO occupancy
err_o  output  1  one-cycle pulse on an illegal write address

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i. Reset values: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, err_o=0, FIFO empty, fifo_count_o=0.
- ex_ready_o = (fifo_count_o < FifoDepth). It is derived from registered state only, so a same-cycle drain never raises it. Right after reset it is 1.
- Output stage is registered, with 1-cycle latency. At each edge, rf_we/waddr/wdata load the winner of the current cycle.
- Priority order:
  1. lsu_valid_i.
  2. FIFO head.
  3. The accepted EX write, which bypasses the FIFO only when the FIFO is empty.
- Loser handling:
  - An accepted EX write that does not win goes to the FIFO tail.
  - If the FIFO head wins while an EX write is accepted, the pop and push happen in the same cycle and the count is unchanged.
- FIFO order is strict; EX writes reach the RF in acceptance order.
- Writes with waddr=0, from either source, are accepted and dropped. They produce no FIFO entry and no rf_we_o.
- RV32E=1 with waddr[4]=1, from either source:
  - the write is dropped;
  - err_o pulses high in the following cycle, registered;
  - an EX write is still handshaken, so no deadlock results.
- No arbitration cycle yields a write: rf_we_o=0 next cycle, and waddr/wdata hold their previous values.
- flush_i:
  - synchronously empties the FIFO;
  - also drops an EX write accepted in the same cycle;
  - does not cancel a same-cycle LSU write or the already-registered output stage.
- Hazards: hazard_x_o=1 when raddr_x_i != 0 and raddr_x_i matches any valid FIFO entry or the output stage (rf_we_o=1). This is purely combinational and excludes incoming same-cycle writes.
- WAW between a pending EX entry and an LSU write to the same register is excluded upstream; the LSU write still wins priority.
- Pointer wrap: read and write pointers wrap modulo FifoDepth; count is tracked separately, so full and empty are unambiguous.

Test Plan:
- Reset, then EX writes x5=0x1111_0000 with LSU idle -> ex_ready_o=1; next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1111_0000; fifo_count_o stays 0.
- LSU x7=0xAAAA and EX x8=0xBBBB in the same cycle -> cycle+1 writes x7; cycle+2 writes x8; fifo_count_o goes 1 then 0.
- LSU valid for 3 cycles while EX offers x1, x2, x3 -> FIFO fills to 2 and ex_ready_o=0 on the third offer. Drain order is x1 then x2, followed by x3. No write is lost or reordered.
- EX write to x0 = 0xDEAD -> handshake completes; rf_we_o stays 0; fifo_count_o stays 0. With RV32E=1, EX write to x20 -> err_o=1 for exactly one cycle; no rf_we_o.
- FIFO holds x9 and x10; raddr_a_i=10, raddr_b_i=0 -> hazard_a_o=1, hazard_b_o=0. Assert flush_i -> next cycle fifo_count_o=0 and hazard_a_o=0.
- Reset asserted with 2 FIFO entries and rf_we_o=1 -> all outputs and the count are 0 immediately; after release, no stale write ever appears.

Source files
------------

// File: rtl/ibex_rf_wb_arbiter.sv
// Merges EX and LSU writebacks onto the single register-file write port.
// EX results that lose to the LSU are queued in order; pending writes are reported as read hazards.
module ibex_rf_wb_arbiter #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    input  logic                 flush_i,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 hazard_a_o,
    output logic                 hazard_b_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic [2:0]           fifo_count_o,
    output logic                 err_o
);

    localparam int unsigned PtrW   = (FifoDepth > 2) ? 2 : 1;
    localparam logic [2:0]  DepthC = 3'(FifoDepth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(FifoDepth - 1);

    logic [PtrW-1:0]      rd_ptr_reg, wr_ptr_reg;
    logic [2:0]           count_reg, count_next;
    logic [FifoDepth-1:0] entry_valid_reg;
    logic [4:0]           fifo_addr_mem [FifoDepth];
    logic [DataWidth-1:0] fifo_data_mem [FifoDepth];

    logic                 rf_we_reg, err_reg;
    logic [4:0]           rf_waddr_reg;
    logic [DataWidth-1:0] rf_wdata_reg;

    logic                 lsu_illegal, ex_illegal, ex_accept;
    logic                 lsu_write, ex_write, fifo_empty, head_avail;
    logic                 pop, push, ex_wins, err_next;
    logic                 win_valid;
    logic [4:0]           win_addr;
    logic [DataWidth-1:0] win_data;
    logic [FifoDepth-1:0] match_a, match_b;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == LastPtr) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign fifo_empty  = (count_reg == 3'd0);
    assign ex_ready_o  = (count_reg < DepthC);
    assign ex_accept   = ex_valid_i && ex_ready_o;

    assign lsu_illegal = RV32E && lsu_waddr_i[4];
    assign ex_illegal  = RV32E && ex_waddr_i[4];

    // x0 and illegal targets are consumed without producing a write
    assign lsu_write   = lsu_valid_i && (lsu_waddr_i != 5'd0) && !lsu_illegal;
    assign ex_write    = ex_accept && (ex_waddr_i != 5'd0) && !ex_illegal && !flush_i;

    // A flush cancels the queued head but never the LSU write of the same cycle
    assign head_avail  = !fifo_empty && !flush_i;
    assign pop         = head_avail && !lsu_write;
    assign ex_wins     = ex_write && fifo_empty && !lsu_write;
    assign push        = ex_write && !ex_wins;
    assign count_next  = count_reg + {2'b00, push} - {2'b00, pop};
    assign err_next    = (lsu_valid_i && lsu_illegal) || (ex_accept && ex_illegal);

    always_comb begin
        win_valid = 1'b0;
        win_addr  = lsu_waddr_i;
        win_data  = lsu_wdata_i;
        if (lsu_write) begin
            win_valid = 1'b1;
        end else if (head_avail) begin
            win_valid = 1'b1;
            win_addr  = fifo_addr_mem[rd_ptr_reg];
            win_data  = fifo_data_mem[rd_ptr_reg];
        end else if (ex_wins) begin
            win_valid = 1'b1;
            win_addr  = ex_waddr_i;
            win_data  = ex_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= 3'd0;
            entry_valid_reg <= '0;
            rf_we_reg       <= 1'b0;
            rf_waddr_reg    <= 5'd0;
            rf_wdata_reg    <= '0;
            err_reg         <= 1'b0;
        end else begin
            if (flush_i) begin
                rd_ptr_reg      <= '0;
                wr_ptr_reg      <= '0;
                count_reg       <= 3'd0;
                entry_valid_reg <= '0;
            end else begin
                if (pop) begin
                    rd_ptr_reg                  <= ptr_inc(rd_ptr_reg);
                    entry_valid_reg[rd_ptr_reg] <= 1'b0;
                end
                if (push) begin
                    wr_ptr_reg                  <= ptr_inc(wr_ptr_reg);
                    entry_valid_reg[wr_ptr_reg] <= 1'b1;
                end
                count_reg <= count_next;
            end
            rf_we_reg <= win_valid;
            if (win_valid) begin
                rf_waddr_reg <= win_addr;
                rf_wdata_reg <= win_data;
            end
            err_reg <= err_next;
        end
    end

    // Payload storage needs no reset; entry_valid_reg qualifies every read
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_reg] <= ex_waddr_i;
            fifo_data_mem[wr_ptr_reg] <= ex_wdata_i;
        end
    end

    generate
        for (genvar gi = 0; gi < FifoDepth; gi++) begin : g_match
            assign match_a[gi] = entry_valid_reg[gi] && (fifo_addr_mem[gi] == raddr_a_i);
            assign match_b[gi] = entry_valid_reg[gi] && (fifo_addr_mem[gi] == raddr_b_i);
        end
    endgenerate

    assign hazard_a_o = (raddr_a_i != 5'd0) &&
                        ((|match_a) || (rf_we_reg && (rf_waddr_reg == raddr_a_i)));
    assign hazard_b_o = (raddr_b_i != 5'd0) &&
                        ((|match_b) || (rf_we_reg && (rf_waddr_reg == raddr_b_i)));

    assign rf_we_o      = rf_we_reg;
    assign rf_waddr_o   = rf_waddr_reg;
    assign rf_wdata_o   = rf_wdata_reg;
    assign fifo_count_o = count_reg;
    assign err_o        = err_reg;

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Directed bench for ibex_rf_wb_arbiter (RV32E=1, depth 2, 32-bit data).
module tb_ibex_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ex_valid = 1'b0, lsu_valid = 1'b0, flush = 1'b0;
    logic        ex_ready;
    logic [4:0]  ex_waddr = '0, lsu_waddr = '0, raddr_a = '0, raddr_b = '0;
    logic [31:0] ex_wdata = '0, lsu_wdata = '0;
    logic        hazard_a, hazard_b, rf_we, err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    ibex_rf_wb_arbiter #(
        .RV32E(1'b1), .DataWidth(32), .FifoDepth(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
        .flush_i(flush), .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
        .hazard_a_o(hazard_a), .hazard_b_o(hazard_b),
        .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .rf_we_o(rf_we),
        .fifo_count_o(fifo_count), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic ev, input logic [4:0] ea, input logic [31:0] ed);
        lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
        ex_valid = ev; ex_waddr = ea; ex_wdata = ed;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || err !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b addr=%0d data=%h err=%b cnt=%0d, required all 0", rf_we, rf_waddr, rf_wdata, err, fifo_count);
        end
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", ex_ready);
        end
        tick();
        rst_ni = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_ex_bypass();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1111_0000);
        #1;
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL bypass_ready: got %b, required 1", ex_ready);
        end
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1111_0000 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL bypass_write: we=%b addr=%0d data=%h cnt=%0d, required 1/5/11110000/0", rf_we, rf_waddr, rf_wdata, fifo_count);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1111_0000) begin
            errors++;
            $display("FAIL idle_hold: we=%b addr=%0d data=%h, required 0/5/11110000", rf_we, rf_waddr, rf_wdata);
        end
        $display("test_ex_bypass done");
    endtask

    task automatic test_lsu_priority();
        drive(1'b1, 5'd7, 32'h0000_AAAA, 1'b1, 5'd8, 32'h0000_BBBB);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        raddr_a = 5'd8;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h0000_AAAA || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL lsu_first: we=%b addr=%0d data=%h cnt=%0d, required 1/7/0000aaaa/1", rf_we, rf_waddr, rf_wdata, fifo_count);
        end
        checks++;
        if (hazard_a !== 1'b1) begin
            errors++;
            $display("FAIL hazard_fifo_x8: got %b, required 1", hazard_a);
        end
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h0000_BBBB || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL ex_second: we=%b addr=%0d data=%h cnt=%0d, required 1/8/0000bbbb/0", rf_we, rf_waddr, rf_wdata, fifo_count);
        end
        checks++;
        if (hazard_a !== 1'b1) begin
            errors++;
            $display("FAIL hazard_out_x8: got %b, required 1", hazard_a);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || hazard_a !== 1'b0) begin
            errors++;
            $display("FAIL after_drain: we=%b hazard_a=%b, required 0/0", rf_we, hazard_a);
        end
        raddr_a = 5'd0;
        $display("test_lsu_priority done");
    endtask

    task automatic test_fifo_fill();
        logic [4:0]  exp_addr [6] = '{5'd11, 5'd12, 5'd13, 5'd1, 5'd2, 5'd3};
        logic [2:0]  exp_cnt  [6] = '{3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
        logic        exp_rdy  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(1'b1, 5'd11, 32'h11, 1'b1, 5'd1, 32'h101);
                1: drive(1'b1, 5'd12, 32'h12, 1'b1, 5'd2, 32'h102);
                2: drive(1'b1, 5'd13, 32'h13, 1'b1, 5'd3, 32'h103);
                3: drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h103);
                4: drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h103);
                default: drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            endcase
            #1;
            if (i < 5) begin
                checks++;
                if (ex_ready !== exp_rdy[i]) begin
                    errors++;
                    $display("FAIL fill_ready[%0d]: got %b, required %b", i, ex_ready, exp_rdy[i]);
                end
            end
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== exp_addr[i] || fifo_count !== exp_cnt[i]) begin
                errors++;
                $display("FAIL fill_step[%0d]: we=%b addr=%0d cnt=%0d, required 1/%0d/%0d", i, rf_we, rf_waddr, fifo_count, exp_addr[i], exp_cnt[i]);
            end
            if (exp_addr[i] == 5'd3) begin
                checks++;
                if (rf_wdata !== 32'h103) begin
                    errors++;
                    $display("FAIL fill_data_x3: got %h, required 00000103", rf_wdata);
                end
            end
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        $display("test_fifo_fill done");
    endtask

    task automatic test_zero_illegal();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
        #1;
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got %b, required 1", ex_ready);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || fifo_count !== 3'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL x0_drop: we=%b cnt=%0d err=%b, required 0/0/0", rf_we, fifo_count, err);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h2020);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (err !== 1'b1 || rf_we !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL x20_err: err=%b we=%b cnt=%0d, required 1/0/0", err, rf_we, fifo_count);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_width: got %b, required 0", err);
        end
        drive(1'b1, 5'd16, 32'h1616, 1'b0, 5'd0, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (err !== 1'b1 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL lsu_x16_err: err=%b we=%b, required 1/0", err, rf_we);
        end
        tick();
        $display("test_zero_illegal done");
    endtask

    task automatic fill_two();
        drive(1'b1, 5'd14, 32'h14, 1'b1, 5'd9, 32'h909);
        tick();
        drive(1'b1, 5'd15, 32'h15, 1'b1, 5'd10, 32'hA0A);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_hazard_flush();
        fill_two();
        raddr_a = 5'd10;
        raddr_b = 5'd0;
        #1;
        checks++;
        if (fifo_count !== 3'd2 || hazard_a !== 1'b1 || hazard_b !== 1'b0) begin
            errors++;
            $display("FAIL hazard_fifo: cnt=%0d ha=%b hb=%b, required 2/1/0", fifo_count, hazard_a, hazard_b);
        end
        raddr_b = 5'd15;
        #1;
        checks++;
        if (hazard_b !== 1'b1) begin
            errors++;
            $display("FAIL hazard_outstage: got %b, required 1", hazard_b);
        end
        raddr_b = 5'd0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (fifo_count !== 3'd0 || hazard_a !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL flush: cnt=%0d ha=%b we=%b, required 0/0/0", fifo_count, hazard_a, rf_we);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_stale: we=%b addr=%0d, required we 0", rf_we, rf_waddr);
        end
        raddr_a = 5'd0;
        $display("test_hazard_flush done");
    endtask

    task automatic test_async_reset();
        fill_two();
        checks++;
        if (fifo_count !== 3'd2 || rf_we !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: cnt=%0d we=%b, required 2/1", fifo_count, rf_we);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || fifo_count !== 3'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: we=%b addr=%0d data=%h cnt=%0d err=%b, required all 0", rf_we, rf_waddr, rf_wdata, fifo_count, err);
        end
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin
                errors++;
                $display("FAIL post_reset[%0d]: we=%b cnt=%0d, required 0/0", i, rf_we, fifo_count);
            end
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_ex_bypass();
        test_lsu_priority();
        test_fifo_fill();
        test_zero_illegal();
        test_hazard_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
